// File: rtl/oled_spi_fifo_manager.sv
// AHB-Lite slave feeding a byte FIFO that drains into an OLED SPI (mode 0) shifter.
// Each FIFO entry carries the byte plus its data/command flag; nCS stays low across queued bytes.
module oled_spi_fifo_manager #(
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_WIDTH  = 8
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic        HREADY,
    input  logic        HWRITE,
    input  logic [31:0] HADDR,
    input  logic [31:0] HWDATA,
    input  logic [2:0]  HSIZE,
    input  logic [1:0]  HTRANS,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        nCS,
    output logic        DnC,
    output logic        SDIN,
    output logic        SCLK,
    output logic        IRQ
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;

    typedef enum logic [1:0] {ST_IDLE, ST_LOW, ST_HIGH} state_t;

    // AHB data-phase bookkeeping
    logic       dph_valid_reg;
    logic       dph_write_reg;
    logic [1:0] dph_addr_reg;

    // FIFO storage and pointers
    logic [8:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [LW-1:0] level_reg, level_next;

    // Control / status registers
    logic [DIV_WIDTH-1:0] div_reg;
    logic                 irq_en_reg;
    logic                 done_reg, done_next;
    logic                 ovf_reg, ovf_next;

    // Shift engine
    state_t               state_reg, state_next;
    logic [2:0]           bit_reg, bit_next;
    logic [DIV_WIDTH-1:0] half_reg, half_next;
    logic [DIV_WIDTH-1:0] divcur_reg, divcur_next;
    logic [7:0]           shift_reg, shift_next;
    logic                 dnc_reg, dnc_next;
    logic                 pop;
    logic                 done_set;

    logic        addr_phase, wr_dph, rd_dph;
    logic        push_req, push_ok, flush, ctrl_wr, w1c;
    logic        full, empty;
    logic [8:0]  head;
    logic [31:0] status_word, ctrl_word;
    logic        unused_bits;

    assign unused_bits = ^{HSIZE, HADDR, HWDATA};

    assign addr_phase = HSEL & HREADY & (HTRANS != 2'b00);
    assign wr_dph     = dph_valid_reg & dph_write_reg;
    assign rd_dph     = dph_valid_reg & ~dph_write_reg;

    assign full     = (level_reg == LW'(FIFO_DEPTH));
    assign empty    = (level_reg == '0);
    assign push_req = wr_dph & (dph_addr_reg == 2'd0);
    assign push_ok  = push_req & ~full;
    assign flush    = wr_dph & (dph_addr_reg == 2'd1) & HWDATA[0];
    assign ctrl_wr  = wr_dph & (dph_addr_reg == 2'd2);
    assign w1c      = wr_dph & (dph_addr_reg == 2'd3);
    assign head     = mem[rd_ptr_reg];

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dph_valid_reg <= 1'b0;
            dph_write_reg <= 1'b0;
            dph_addr_reg  <= 2'd0;
        end else begin
            dph_valid_reg <= addr_phase;
            dph_write_reg <= HWRITE;
            dph_addr_reg  <= HADDR[3:2];
        end
    end

    // Storage has no reset so it can map onto RAM primitives.
    always_ff @(posedge HCLK) begin
        if (push_ok)
            mem[wr_ptr_reg] <= HWDATA[8:0];
    end

    always_comb begin
        level_next = level_reg;
        case ({push_ok, pop})
            2'b10:   level_next = level_reg + LW'(1);
            2'b01:   level_next = level_reg - LW'(1);
            default: level_next = level_reg;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (push_ok)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            level_reg <= level_next;
        end
    end

    // Set wins over a same-cycle write-one-to-clear.
    assign done_next = done_set | (done_reg & ~(w1c & HWDATA[0]));
    assign ovf_next  = (push_req & full) | (ovf_reg & ~(w1c & HWDATA[1]));

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            div_reg    <= DIV_WIDTH'(1);
            irq_en_reg <= 1'b0;
            done_reg   <= 1'b0;
            ovf_reg    <= 1'b0;
        end else begin
            if (ctrl_wr) begin
                div_reg    <= HWDATA[DIV_WIDTH-1:0];
                irq_en_reg <= HWDATA[16];
            end
            done_reg <= done_next;
            ovf_reg  <= ovf_next;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_reg  <= ST_IDLE;
            bit_reg    <= 3'd0;
            half_reg   <= '0;
            divcur_reg <= '0;
            shift_reg  <= 8'd0;
            dnc_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            bit_reg    <= bit_next;
            half_reg   <= half_next;
            divcur_reg <= divcur_next;
            shift_reg  <= shift_next;
            dnc_reg    <= dnc_next;
        end
    end

    // Divider is sampled at the start of each half period so CTRL writes never stretch one mid-way.
    always_comb begin
        state_next  = state_reg;
        bit_next    = bit_reg;
        half_next   = half_reg;
        divcur_next = divcur_reg;
        shift_next  = shift_reg;
        dnc_next    = dnc_reg;
        pop         = 1'b0;
        done_set    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (!empty) begin
                    pop         = 1'b1;
                    shift_next  = head[7:0];
                    dnc_next    = head[8];
                    bit_next    = 3'd0;
                    half_next   = '0;
                    divcur_next = div_reg;
                    state_next  = ST_LOW;
                end
            end
            ST_LOW: begin
                if (half_reg == divcur_reg) begin
                    half_next   = '0;
                    divcur_next = div_reg;
                    state_next  = ST_HIGH;
                end else begin
                    half_next = half_reg + 1'b1;
                end
            end
            ST_HIGH: begin
                if (half_reg == divcur_reg) begin
                    half_next   = '0;
                    divcur_next = div_reg;
                    if (bit_reg != 3'd7) begin
                        shift_next = {shift_reg[6:0], 1'b0};
                        bit_next   = bit_reg + 3'd1;
                        state_next = ST_LOW;
                    end else if (!empty) begin
                        pop        = 1'b1;
                        shift_next = head[7:0];
                        dnc_next   = head[8];
                        bit_next   = 3'd0;
                        state_next = ST_LOW;
                    end else begin
                        done_set   = 1'b1;
                        state_next = ST_IDLE;
                    end
                end else begin
                    half_next = half_reg + 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign nCS  = (state_reg == ST_IDLE);
    assign SCLK = (state_reg == ST_HIGH);
    assign SDIN = (state_reg != ST_IDLE) & shift_reg[7];
    assign DnC  = (state_reg != ST_IDLE) & dnc_reg;
    assign IRQ  = irq_en_reg & (done_reg | ovf_reg);
    assign HREADYOUT = 1'b1;

    always_comb begin
        status_word       = '0;
        status_word[0]    = empty;
        status_word[1]    = full;
        status_word[2]    = (state_reg != ST_IDLE);
        status_word[15:8] = 8'(level_reg);
        ctrl_word                  = '0;
        ctrl_word[DIV_WIDTH-1:0]   = div_reg;
        ctrl_word[16]              = irq_en_reg;
    end

    always_comb begin
        HRDATA = '0;
        if (rd_dph) begin
            case (dph_addr_reg)
                2'd1:    HRDATA = status_word;
                2'd2:    HRDATA = ctrl_word;
                2'd3:    HRDATA = {30'd0, ovf_reg, done_reg};
                default: HRDATA = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_oled_spi_fifo_manager.sv
// Directed bench for oled_spi_fifo_manager: AHB register access plus SPI waveform capture and decode.
module tb_oled_spi_fifo_manager;

    localparam int MAXR = 2048;
    localparam logic [31:0] A_TX   = 32'h0;
    localparam logic [31:0] A_STAT = 32'h4;
    localparam logic [31:0] A_CTRL = 32'h8;
    localparam logic [31:0] A_IRQ  = 32'hC;

    logic        HCLK, HRESETn, HSEL, HREADY, HWRITE;
    logic [31:0] HADDR, HWDATA, HRDATA;
    logic [2:0]  HSIZE;
    logic [1:0]  HTRANS;
    logic        HREADYOUT, nCS, DnC, SDIN, SCLK, IRQ;

    int checks = 0;
    int errors = 0;

    logic tr_cs [MAXR], tr_sclk [MAXR], tr_sdin [MAXR], tr_dnc [MAXR], tr_irq [MAXR];
    int   rec_n = 0;
    bit   rec_en = 0;

    int          a_rise, a_csfall, a_hw_bad, a_lw_bad, a_unstable, a_irq_rise, a_irq_first, a_cs_rise;
    logic [31:0] a_bits, a_dnc;
    logic [31:0] burst_data [16];

    oled_spi_fifo_manager #(.FIFO_DEPTH(8), .DIV_WIDTH(8)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HREADY(HREADY), .HWRITE(HWRITE),
        .HADDR(HADDR), .HWDATA(HWDATA), .HSIZE(HSIZE), .HTRANS(HTRANS),
        .HRDATA(HRDATA), .HREADYOUT(HREADYOUT),
        .nCS(nCS), .DnC(DnC), .SDIN(SDIN), .SCLK(SCLK), .IRQ(IRQ)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    initial begin
        forever begin
            @(posedge HCLK);
            #1;
            if (rec_en && rec_n < MAXR) begin
                tr_cs[rec_n]   = nCS;
                tr_sclk[rec_n] = SCLK;
                tr_sdin[rec_n] = SDIN;
                tr_dnc[rec_n]  = DnC;
                tr_irq[rec_n]  = IRQ;
                rec_n++;
            end
        end
    end

    task automatic ahb_write(input logic [31:0] addr, input logic [31:0] data);
        @(posedge HCLK); #1;
        HSEL = 1; HTRANS = 2'b10; HWRITE = 1; HADDR = addr;
        @(posedge HCLK); #1;
        HSEL = 0; HTRANS = 2'b00; HWRITE = 0; HWDATA = data;
        @(posedge HCLK); #1;
        $display("write addr=%0h data=%0h", addr, data);
    endtask

    task automatic ahb_read(input logic [31:0] addr, output logic [31:0] data);
        @(posedge HCLK); #1;
        HSEL = 1; HTRANS = 2'b10; HWRITE = 0; HADDR = addr;
        @(posedge HCLK); #1;
        HSEL = 0; HTRANS = 2'b00;
        data = HRDATA;
        $display("read  addr=%0h data=%0h", addr, data);
    endtask

    // Pipelined TXDATA writes, one per cycle, from burst_data.
    task automatic ahb_burst(input int n);
        for (int i = 0; i <= n; i++) begin
            @(posedge HCLK); #1;
            if (i < n) begin
                HSEL = 1; HTRANS = 2'b10; HWRITE = 1; HADDR = A_TX;
            end else begin
                HSEL = 0; HTRANS = 2'b00; HWRITE = 0;
            end
            if (i > 0) HWDATA = burst_data[i-1];
        end
        @(posedge HCLK); #1;
        $display("burst of %0d TXDATA writes", n);
    endtask

    task automatic rec_start();
        rec_n = 0;
        rec_en = 1;
    endtask

    task automatic wait_xfer(input int budget);
        int n = 0;
        while (nCS !== 1'b0 && n < budget) begin @(posedge HCLK); #1; n++; end
        while (nCS !== 1'b1 && n < budget) begin @(posedge HCLK); #1; n++; end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL xfer_timeout: waited %0d cycles, required completion within %0d", n, budget);
        end
        repeat (3) begin @(posedge HCLK); #1; end
    endtask

    // Decodes the captured trace: SCLK rising edges while selected, pulse widths, IRQ edges.
    task automatic analyze(input int width);
        int hrun = 0;
        int lrun = 0;
        a_rise = 0; a_csfall = 0; a_hw_bad = 0; a_lw_bad = 0; a_unstable = 0;
        a_irq_rise = 0; a_irq_first = -1; a_cs_rise = -1; a_bits = 0; a_dnc = 0;
        for (int i = 1; i < rec_n; i++) begin
            if (tr_cs[i-1] && !tr_cs[i]) a_csfall++;
            if (!tr_cs[i-1] && tr_cs[i]) a_cs_rise = i;
            if (!tr_irq[i-1] && tr_irq[i]) begin
                if (a_irq_rise == 0) a_irq_first = i;
                a_irq_rise++;
            end
            if (!tr_cs[i] && !tr_sclk[i-1] && tr_sclk[i]) begin
                a_rise++;
                a_bits = {a_bits[30:0], tr_sdin[i]};
                a_dnc  = {a_dnc[30:0], tr_dnc[i]};
                if (tr_sdin[i] !== tr_sdin[i-1] || tr_dnc[i] !== tr_dnc[i-1]) a_unstable++;
            end
            if (!tr_cs[i] && tr_sclk[i]) hrun++;
            else begin
                if (hrun != 0 && hrun != width) a_hw_bad++;
                hrun = 0;
            end
            if (!tr_cs[i] && !tr_sclk[i]) lrun++;
            else begin
                if (lrun != 0 && lrun != width) a_lw_bad++;
                lrun = 0;
            end
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        HRESETn = 0; HSEL = 0; HREADY = 1; HWRITE = 0; HADDR = 0; HWDATA = 0;
        HSIZE = 3'b010; HTRANS = 2'b00;
        #3;
        checks++; if (nCS !== 1'b1) begin errors++; $display("FAIL rst_ncs: got %b expected 1", nCS); end
        checks++; if (SCLK !== 1'b0) begin errors++; $display("FAIL rst_sclk: got %b expected 0", SCLK); end
        checks++; if (SDIN !== 1'b0) begin errors++; $display("FAIL rst_sdin: got %b expected 0", SDIN); end
        checks++; if (DnC !== 1'b0) begin errors++; $display("FAIL rst_dnc: got %b expected 0", DnC); end
        checks++; if (IRQ !== 1'b0) begin errors++; $display("FAIL rst_irq: got %b expected 0", IRQ); end
        checks++; if (HRDATA !== 32'h0) begin errors++; $display("FAIL rst_hrdata: got %h expected 0", HRDATA); end
        checks++; if (HREADYOUT !== 1'b1) begin errors++; $display("FAIL rst_hreadyout: got %b expected 1", HREADYOUT); end
        repeat (3) @(posedge HCLK);
        #1 HRESETn = 1;
        ahb_read(A_STAT, d);
        checks++; if (d !== 32'h1) begin errors++; $display("FAIL idle_status: got %h expected 00000001", d); end
        checks++; if (HREADYOUT !== 1'b1) begin errors++; $display("FAIL hreadyout_read: got %b expected 1", HREADYOUT); end
        @(posedge HCLK); #1;
        checks++; if (HRDATA !== 32'h0) begin errors++; $display("FAIL hrdata_idle: got %h expected 0", HRDATA); end
        ahb_read(A_CTRL, d);
        checks++; if (d !== 32'h1) begin errors++; $display("FAIL idle_ctrl: got %h expected 00000001", d); end
        ahb_read(A_IRQ, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL idle_irqstat: got %h expected 0", d); end
        ahb_read(A_TX, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL txdata_read: got %h expected 0", d); end
    endtask

    task automatic test_single_byte();
        logic [31:0] d;
        ahb_write(A_CTRL, 32'h1);
        rec_start();
        ahb_write(A_TX, 32'h1A5);
        checks++; if (nCS !== 1'b1) begin errors++; $display("FAIL pop_latency_ncs_high: got %b expected 1", nCS); end
        @(posedge HCLK); #1;
        checks++; if (nCS !== 1'b0) begin errors++; $display("FAIL ncs_fall_latency: got %b expected 0", nCS); end
        checks++; if (DnC !== 1'b1) begin errors++; $display("FAIL single_dnc: got %b expected 1", DnC); end
        wait_xfer(200);
        rec_en = 0;
        analyze(2);
        checks++; if (a_rise !== 8) begin errors++; $display("FAIL single_edges: got %0d expected 8", a_rise); end
        checks++; if (a_bits[7:0] !== 8'hA5) begin errors++; $display("FAIL single_bits: got %h expected a5", a_bits[7:0]); end
        checks++; if (a_dnc[7:0] !== 8'hFF) begin errors++; $display("FAIL single_dnc_bits: got %h expected ff", a_dnc[7:0]); end
        checks++; if (a_hw_bad !== 0 || a_lw_bad !== 0) begin errors++; $display("FAIL single_widths: got %0d/%0d bad high/low phases expected 0/0", a_hw_bad, a_lw_bad); end
        checks++; if (a_unstable !== 0) begin errors++; $display("FAIL single_setup: got %0d unstable edges expected 0", a_unstable); end
        checks++; if (a_csfall !== 1) begin errors++; $display("FAIL single_cs: got %0d nCS falls expected 1", a_csfall); end
        ahb_read(A_IRQ, d);
        checks++; if (d !== 32'h1) begin errors++; $display("FAIL single_done: got %h expected 00000001", d); end
        checks++; if (IRQ !== 1'b0) begin errors++; $display("FAIL irq_masked: got %b expected 0", IRQ); end
        ahb_write(A_IRQ, 32'h1);
        ahb_read(A_IRQ, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL done_w1c: got %h expected 0", d); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        ahb_write(A_CTRL, 32'h10001);
        burst_data[0] = 32'h0AE; burst_data[1] = 32'h1FF; burst_data[2] = 32'h000;
        rec_start();
        ahb_burst(3);
        wait_xfer(400);
        rec_en = 0;
        analyze(2);
        checks++; if (a_rise !== 24) begin errors++; $display("FAIL b2b_edges: got %0d expected 24", a_rise); end
        checks++; if (a_bits[23:0] !== 24'hAEFF00) begin errors++; $display("FAIL b2b_bits: got %h expected aeff00", a_bits[23:0]); end
        checks++; if (a_dnc[23:0] !== 24'h00FF00) begin errors++; $display("FAIL b2b_dnc: got %h expected 00ff00", a_dnc[23:0]); end
        checks++; if (a_csfall !== 1) begin errors++; $display("FAIL b2b_cs_continuous: got %0d nCS falls expected 1", a_csfall); end
        checks++; if (a_hw_bad !== 0 || a_lw_bad !== 0) begin errors++; $display("FAIL b2b_widths: got %0d/%0d bad high/low phases expected 0/0", a_hw_bad, a_lw_bad); end
        checks++; if (a_irq_rise !== 1) begin errors++; $display("FAIL b2b_single_done: got %0d IRQ rises expected 1", a_irq_rise); end
        checks++; if (a_irq_first !== a_cs_rise) begin errors++; $display("FAIL b2b_done_at_end: got IRQ rise at %0d expected %0d", a_irq_first, a_cs_rise); end
        ahb_write(A_IRQ, 32'h1);
        ahb_write(A_CTRL, 32'h1);
        ahb_read(A_IRQ, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL b2b_cleanup: got %h expected 0", d); end
    endtask

    task automatic test_overflow();
        logic [31:0] d;
        ahb_write(A_CTRL, 32'h0);
        for (int i = 0; i < 10; i++) burst_data[i] = 32'h10 + i;
        ahb_burst(10);
        ahb_read(A_STAT, d);
        checks++; if (d !== 32'h0806) begin errors++; $display("FAIL ovf_status: got %h expected 00000806", d); end
        ahb_read(A_IRQ, d);
        checks++; if (d !== 32'h2) begin errors++; $display("FAIL ovf_flag: got %h expected 00000002", d); end
        checks++; if (IRQ !== 1'b0) begin errors++; $display("FAIL ovf_irq_masked: got %b expected 0", IRQ); end
        ahb_write(A_CTRL, 32'h10000);
        checks++; if (IRQ !== 1'b1) begin errors++; $display("FAIL ovf_irq_enabled: got %b expected 1", IRQ); end
        ahb_write(A_IRQ, 32'h2);
        ahb_read(A_IRQ, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL ovf_w1c: got %h expected 0", d); end
        checks++; if (IRQ !== 1'b0) begin errors++; $display("FAIL ovf_irq_cleared: got %b expected 0", IRQ); end
        wait_xfer(600);
        ahb_read(A_IRQ, d);
        checks++; if (d !== 32'h1) begin errors++; $display("FAIL ovf_drain_done: got %h expected 00000001", d); end
        checks++; if (IRQ !== 1'b1) begin errors++; $display("FAIL ovf_done_irq: got %b expected 1", IRQ); end
        ahb_read(A_STAT, d);
        checks++; if (d !== 32'h1) begin errors++; $display("FAIL ovf_drained: got %h expected 00000001", d); end
        ahb_write(A_IRQ, 32'h3);
        ahb_write(A_CTRL, 32'h1);
    endtask

    task automatic test_flush();
        logic [31:0] d;
        burst_data[0] = 32'h011; burst_data[1] = 32'h022; burst_data[2] = 32'h033; burst_data[3] = 32'h044;
        rec_start();
        ahb_burst(4);
        ahb_write(A_STAT, 32'h1);
        ahb_read(A_STAT, d);
        checks++; if (d !== 32'h5) begin errors++; $display("FAIL flush_status_busy: got %h expected 00000005", d); end
        wait_xfer(300);
        rec_en = 0;
        analyze(2);
        checks++; if (a_rise !== 8) begin errors++; $display("FAIL flush_edges: got %0d expected 8", a_rise); end
        checks++; if (a_bits[7:0] !== 8'h11) begin errors++; $display("FAIL flush_byte: got %h expected 11", a_bits[7:0]); end
        ahb_read(A_STAT, d);
        checks++; if (d !== 32'h1) begin errors++; $display("FAIL flush_idle: got %h expected 00000001", d); end
        ahb_read(A_IRQ, d);
        checks++; if (d !== 32'h1) begin errors++; $display("FAIL flush_done: got %h expected 00000001", d); end
        ahb_write(A_IRQ, 32'h1);
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        int   n = 0;
        int   rises = 0;
        int   bad = 0;
        logic prev_sclk = 1'b0;
        ahb_write(A_CTRL, 32'h3);
        ahb_write(A_TX, 32'h0FF);
        while (rises < 5 && n < 300) begin
            @(posedge HCLK); #1;
            if (!prev_sclk && SCLK) rises++;
            prev_sclk = SCLK;
            n++;
        end
        checks++; if (rises !== 5) begin errors++; $display("FAIL mid_reach_bit4: got %0d edges expected 5", rises); end
        #2 HRESETn = 0;
        #1;
        checks++; if (nCS !== 1'b1) begin errors++; $display("FAIL mid_rst_ncs: got %b expected 1", nCS); end
        checks++; if (SCLK !== 1'b0) begin errors++; $display("FAIL mid_rst_sclk: got %b expected 0", SCLK); end
        checks++; if (SDIN !== 1'b0) begin errors++; $display("FAIL mid_rst_sdin: got %b expected 0", SDIN); end
        repeat (2) @(posedge HCLK);
        #1 HRESETn = 1;
        for (int i = 0; i < 40; i++) begin
            @(posedge HCLK); #1;
            if (SCLK !== 1'b0 || nCS !== 1'b1) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL mid_no_edges: got %0d active cycles expected 0", bad); end
        ahb_read(A_STAT, d);
        checks++; if (d !== 32'h1) begin errors++; $display("FAIL mid_status: got %h expected 00000001", d); end
        ahb_read(A_CTRL, d);
        checks++; if (d !== 32'h1) begin errors++; $display("FAIL mid_ctrl_reset: got %h expected 00000001", d); end
        checks++; if (HREADYOUT !== 1'b1) begin errors++; $display("FAIL mid_hreadyout: got %b expected 1", HREADYOUT); end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_overflow();
        test_flush();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/oled_spi_fifo_manager.md
OLED_SPI_FIFO_MANAGER -- requirements
Module: oled_spi_fifo_manager

Interface
REQ-001 Parameter FIFO_DEPTH, default 8: transmit FIFO entries; power of two, >= 2.
REQ-002 Parameter DIV_WIDTH, default 8: width of the SCLK half-period divider field, 1..16.
REQ-003 HCLK  in  1  clock; all state on rising edge.
REQ-004 HRESETn  in  1  reset, asynchronous, active-low.
REQ-005 HSEL, HREADY, HWRITE  in  1 each  AHB-Lite select, ready-in, write.
REQ-006 HADDR  in  32  address; only HADDR[3:2] decoded.
REQ-007 HWDATA  in  32  write data.
REQ-008 HSIZE  in  3; HTRANS  in  2.  HSIZE ignored (word only); HTRANS==2'b00 is no transfer.
REQ-009 HRDATA  out  32  read data; HREADYOUT  out  1  tied high, zero wait states.
REQ-010 nCS, DnC, SDIN, SCLK  out  1 each  OLED SPI: chip select (low active), data/command, serial data, serial clock.
REQ-011 IRQ  out  1  level interrupt.

Function
REQ-012 Register map by HADDR[3:2]: 0 TXDATA (W), 1 STATUS (R; W=flush), 2 CTRL (R/W), 3 IRQSTAT (R; W1C).
REQ-013 Address phase qualified by HSEL & HREADY & HTRANS!=0 is registered; write data/read data use the following cycle (data phase).
REQ-014 TXDATA write: push {HWDATA[8] as DnC, HWDATA[7:0]}; if FIFO full at that data-phase cycle, entry dropped and OVF flag set, even if a pop occurs the same cycle.
REQ-015 STATUS read: [0] empty, [1] full, [2] busy (engine not IDLE), [15:8] FIFO level (0..FIFO_DEPTH), other bits 0.
REQ-016 STATUS write with HWDATA[0]=1: FIFO emptied; byte currently shifting completes normally.
REQ-017 CTRL: [DIV_WIDTH-1:0] DIV, [16] IRQ_EN; reset DIV=1, IRQ_EN=0; unused bits read 0.
REQ-018 IRQSTAT: [0] DONE, [1] OVF; writing 1 to a bit clears it; set has priority over clear in the same cycle.
REQ-019 IRQ = IRQ_EN & (DONE | OVF), combinational from registers.
REQ-020 Reads of TXDATA return 0; HRDATA is 0 in any cycle not in a read data phase.
REQ-021 Engine states IDLE, LOW, HIGH; bit counter 0..7; half-period counter 0..DIV.
REQ-022 IDLE: nCS=1, SCLK=0; if FIFO not empty: pop, load shift register and DnC latch, bit=0 -> LOW.
REQ-023 LOW: nCS=0, SCLK=0, SDIN=shift[7], DnC=latched value; after DIV+1 cycles -> HIGH.
REQ-024 HIGH: nCS=0, SCLK=1; after DIV+1 cycles: if bit<7, shift left, bit+1 -> LOW; if bit==7 and FIFO not empty, pop/load next entry -> LOW (nCS stays low); else -> IDLE and set DONE.
REQ-025 Byte time = 16*(DIV+1) HCLK cycles; MSB first; SDIN and DnC stable across every rising SCLK edge (SPI mode 0).
REQ-026 DIV==0 treated as 1 half-period of one cycle (DIV+1 rule); DIV change takes effect at the next half-period start.
REQ-027 FIFO pointers wrap modulo FIFO_DEPTH; level width clog2(FIFO_DEPTH)+1; simultaneous push and pop on non-full, non-empty FIFO leaves level unchanged.
REQ-028 Push to empty FIFO while IDLE: pop occurs in the cycle after the push data phase, nCS falls the cycle after that.

Reset
REQ-029 On HRESETn low, immediately: nCS=1, SCLK=0, SDIN=0, DnC=0, IRQ=0, HRDATA=0, HREADYOUT=1.
REQ-030 Reset clears FIFO, engine to IDLE, counters 0, DONE=OVF=0, CTRL to reset values; mid-transfer reset aborts the byte with no further SCLK edges.

Verification
REQ-031 Write TXDATA 0x1A5, DIV=1 -> nCS low, DnC=1, 8 SCLK pulses each 2 cycles high/2 low, SDIN 1,0,1,0,0,1,0,1, nCS high after, DONE=1.
REQ-032 Push 3 entries 0x0AE,0x1FF,0x000 back-to-back -> nCS low continuously for 24 bits, DnC 0/1/0 per byte, single DONE at end.
REQ-033 DIV=0, push FIFO_DEPTH+2 entries while engine stalled on first byte -> level saturates at 8, full=1, OVF=1, IRQ=1 only after IRQ_EN=1; W1C 0x2 clears OVF.
REQ-034 Flush during byte 1 of 4 -> byte 1 completes, level 0, engine returns IDLE, DONE set.
REQ-035 Assert HRESETn low during bit 4 -> nCS=1, SCLK=0 same instant; after release STATUS reads empty=1, busy=0, level 0.
REQ-036 IDLE read of STATUS, CTRL, IRQSTAT after reset -> 0x00000001, 0x00000001, 0x00000000; HREADYOUT high throughout.
